// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: iCE40 pixel-PLL reset/lock sequencer with bounded retries, lock qualification and loss counting
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 12,
    parameter int LOCK_TIMEOUT  = 1200,
    parameter int STABLE_CYCLES = 12000,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 16,
    parameter int LOSS_W        = 4
) (
    input  logic              clock_in,
    input  logic              resetb,
    input  logic              pll_locked,
    input  logic              restart,
    output logic              pll_resetb,
    output logic              ready,
    output logic              fault,
    output logic [2:0]        state,
    output logic [3:0]        retry_count,
    output logic [LOSS_W-1:0] loss_count
);
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        retry_q, retry_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              meta_q, lock_s_q;
    logic              failed;

    // Two-flop synchronizer for the PLL LOCK pin, which is asynchronous to clock_in
    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            meta_q   <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            meta_q   <= pll_locked;
            lock_s_q <= meta_q;
        end
    end

    // Sequencer registers
    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            state_q <= RESET_PLL;
            cnt_q   <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    // Next state: restart first, then lock events, then timeouts; a failed attempt retries or faults
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        failed  = 1'b0;
        if (restart) begin
            state_d = RESET_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: state_d = (cnt_q == CNT_W'(RST_CYCLES - 1)) ? WAIT_LOCK : RESET_PLL;
                WAIT_LOCK: begin
                    state_d = lock_s_q ? STABLE : WAIT_LOCK;
                    failed  = !lock_s_q && (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
                end
                STABLE: begin
                    failed  = !lock_s_q;
                    state_d = (lock_s_q && cnt_q == CNT_W'(STABLE_CYCLES - 1)) ? RUN : STABLE;
                end
                RUN: begin
                    state_d = lock_s_q ? RUN : RESET_PLL;
                    loss_d  = (!lock_s_q && !(&loss_q)) ? loss_q + LOSS_W'(1) : loss_q;
                end
                default: state_d = FAULT;
            endcase
            if (failed) begin
                state_d = (retry_q == 4'(MAX_RETRIES)) ? FAULT : RESET_PLL;
                retry_d = (retry_q == 4'(MAX_RETRIES)) ? retry_q : retry_q + 4'd1;
            end
            if (state_d == RUN && state_q != RUN) retry_d = '0;
        end
        cnt_d = (restart || state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    end

    assign state       = state_q;
    assign ready       = (state_q == RUN);
    assign fault       = (state_q == FAULT);
    assign pll_resetb  = (state_q == WAIT_LOCK) || (state_q == STABLE) || (state_q == RUN);
    assign retry_count = retry_q;
    assign loss_count  = loss_q;
endmodule
